gate_sweep_checker: RTL and testbench

- Synthesisable, self-checking exhaustive tester for an N-input combinational gate.
- Drives all 2^N_IN input vectors in ascending order and holds each for a programmable number of cycles.
- Samples the gate's output, compares it against a golden model for the selected logic function, then reports pass/fail, error count and first failing vector.
- Sits beside gate-level cells (NOR/NAND/etc.) as an on-chip or bench-level verification engine, controlled by a start/done handshake.

---
 rtl/gate_sweep_pkg.sv | 28 ++
 rtl/gate_ref_model.sv | 32 +++
 rtl/gate_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_pkg
// Description : Mode encodings, FSM states and mode validation helper shared by
//               the gate sweep checker and its golden model.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

    localparam logic [2:0] MODE_NOR  = 3'd0;
    localparam logic [2:0] MODE_NAND = 3'd1;
    localparam logic [2:0] MODE_AND  = 3'd2;
    localparam logic [2:0] MODE_OR   = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_valid_mode(input logic [2:0] mode);
        return (mode <= MODE_XNOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational golden model; reduction of the stimulus vector
//               under the selected logic function.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] i_stim,
    input  logic [2:0]      i_mode,
    output logic            o_expected
);

    always_comb begin
        o_expected = 1'b0;
        case (i_mode)
            MODE_NOR:  o_expected = ~|i_stim;
            MODE_NAND: o_expected = ~&i_stim;
            MODE_AND:  o_expected = &i_stim;
            MODE_OR:   o_expected = |i_stim;
            MODE_XOR:  o_expected = ^i_stim;
            MODE_XNOR: o_expected = ~^i_stim;
            default:   o_expected = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Exhaustive sweep tester for an N-input gate; drives every input
//               vector, samples the gate and reports pass/fail and error info.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_mode,
    output logic [N_IN-1:0]  o_stim,
    input  logic             i_dut_f,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_mode_err,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_first_err_valid,
    output logic [N_IN-1:0]  o_first_err_vec
);

    localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN:0]     c_VEC_LAST  = (N_IN + 1)'((1 << N_IN) - 1);

    state_t            r_state;
    logic [2:0]        r_mode;
    logic [N_IN:0]     r_vec;
    logic [HOLD_W-1:0] r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_mode_err;
    logic [ERR_W-1:0]  r_err;
    logic              r_first_valid;
    logic [N_IN-1:0]   r_first_vec;

    logic              w_expected;
    logic              w_sample;
    logic              w_mismatch;
    logic [ERR_W-1:0]  w_err_next;

    gate_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .i_stim     (r_vec[N_IN-1:0]),
        .i_mode     (r_mode),
        .o_expected (w_expected)
    );

    assign w_sample   = (r_state == ST_DRIVE) && (r_hold == c_HOLD_LAST);
    assign w_mismatch = w_sample && (i_dut_f != w_expected);
    assign w_err_next = (w_mismatch && !(&r_err)) ? r_err + ERR_W'(1) : r_err;

    // r_vec is kept at zero outside DRIVE, and its low bits are zero at the
    // terminal count, so it can drive the stimulus directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_NOR;
            r_vec         <= '0;
            r_hold        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_mode_err    <= 1'b0;
            r_err         <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_vec  <= '0;
                    r_hold <= '0;
                    if (i_start) begin
                        r_err         <= '0;
                        r_first_valid <= 1'b0;
                        r_first_vec   <= '0;
                        r_pass        <= 1'b0;
                        if (is_valid_mode(i_mode)) begin
                            r_mode     <= i_mode;
                            r_mode_err <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_DRIVE;
                        end else begin
                            r_mode_err <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (w_sample) begin
                        r_err <= w_err_next;
                        if (w_mismatch && !r_first_valid) begin
                            r_first_valid <= 1'b1;
                            r_first_vec   <= r_vec[N_IN-1:0];
                        end
                        r_hold <= '0;
                        r_vec  <= r_vec + (N_IN + 1)'(1);
                        if (r_vec == c_VEC_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_vec   <= '0;
                    r_hold  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_vec   <= '0;
                    r_hold  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stim            = r_vec[N_IN-1:0];
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_mode_err        = r_mode_err;
    assign o_err_count       = r_err;
    assign o_first_err_valid = r_first_valid;
    assign o_first_err_vec   = r_first_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Directed self-checking bench for gate_sweep_checker using three
//               configurations (N_IN=2, N_IN=3, N_IN=3 with a 2-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] mode;
    int         sel;
    logic       stuck2;

    always #5 clk = ~clk;

    // Per-instance wiring
    logic       start2, start3, start3s;
    logic [1:0] stim2;
    logic [2:0] stim3, stim3s, fvec3, fvec3s;
    logic [1:0] fvec2;
    logic       f2, f3, f3s;
    logic       busy2, busy3, busy3s, done2, done3, done3s;
    logic       pass2, pass3, pass3s, merr2, merr3, merr3s;
    logic       fev2, fev3, fev3s;
    logic [7:0] err2, err3;
    logic [1:0] err3s;

    assign start2  = start && (sel == 0);
    assign start3  = start && (sel == 1);
    assign start3s = start && (sel == 2);

    // Gates under test: NOR (optionally stuck at 0), 3-input NAND, 3-input XOR
    assign f2  = stuck2 ? 1'b0 : ~|stim2;
    assign f3  = ~&stim3;
    assign f3s = ^stim3s;

    gate_sweep_checker #(.N_IN(2), .HOLD_CYCLES(HOLD), .ERR_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start2), .i_mode(mode),
        .o_stim(stim2), .i_dut_f(f2), .o_busy(busy2), .o_done(done2),
        .o_pass(pass2), .o_mode_err(merr2), .o_err_count(err2),
        .o_first_err_valid(fev2), .o_first_err_vec(fvec2)
    );

    gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(HOLD), .ERR_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start3), .i_mode(mode),
        .o_stim(stim3), .i_dut_f(f3), .o_busy(busy3), .o_done(done3),
        .o_pass(pass3), .o_mode_err(merr3), .o_err_count(err3),
        .o_first_err_valid(fev3), .o_first_err_vec(fvec3)
    );

    gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(HOLD), .ERR_W(2)) u_dut3s (
        .clk(clk), .rst_n(rst_n), .i_start(start3s), .i_mode(mode),
        .o_stim(stim3s), .i_dut_f(f3s), .o_busy(busy3s), .o_done(done3s),
        .o_pass(pass3s), .o_mode_err(merr3s), .o_err_count(err3s),
        .o_first_err_valid(fev3s), .o_first_err_vec(fvec3s)
    );

    // Selected-instance view, zero-extended
    logic       mx_busy, mx_done, mx_pass, mx_merr, mx_fev;
    logic [7:0] mx_stim, mx_err, mx_fvec;

    always_comb begin
        mx_busy = busy2; mx_done = done2; mx_pass = pass2; mx_merr = merr2;
        mx_fev  = fev2;  mx_stim = {6'd0, stim2}; mx_err = err2;
        mx_fvec = {6'd0, fvec2};
        case (sel)
            1: begin
                mx_busy = busy3; mx_done = done3; mx_pass = pass3; mx_merr = merr3;
                mx_fev  = fev3;  mx_stim = {5'd0, stim3}; mx_err = err3;
                mx_fvec = {5'd0, fvec3};
            end
            2: begin
                mx_busy = busy3s; mx_done = done3s; mx_pass = pass3s; mx_merr = merr3s;
                mx_fev  = fev3s;  mx_stim = {5'd0, stim3s}; mx_err = {6'd0, err3s};
                mx_fvec = {5'd0, fvec3s};
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Launch a run on the selected instance and follow it to its done pulse.
    // The mode bus is scrambled right after launch; the latched mode must hold.
    task automatic run_sweep(input int which, input logic [2:0] m,
                             output int busy_cyc, output int seq_err,
                             output bit done_seen);
        sel = which;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 3'd7;
        busy_cyc  = 0;
        seq_err   = 0;
        done_seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (mx_done) begin
                done_seen = 1'b1;
                break;
            end
            if (mx_busy) begin
                if (int'(mx_stim) != busy_cyc / HOLD) seq_err++;
                busy_cyc++;
            end
            @(negedge clk);
        end
    endtask

    int busy_cyc, seq_err;
    bit done_seen;
    bit busy_rose, stim_moved;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 3'd0;
        sel    = 0;
        stuck2 = 1'b0;
        repeat (3) @(negedge clk);

        check_value("rst_stim",  {24'd0, mx_stim}, 32'd0);
        check_value("rst_busy",  {31'd0, mx_busy}, 32'd0);
        check_value("rst_done",  {31'd0, mx_done}, 32'd0);
        check_value("rst_pass",  {31'd0, mx_pass}, 32'd0);
        check_value("rst_merr",  {31'd0, mx_merr}, 32'd0);
        check_value("rst_err",   {24'd0, mx_err},  32'd0);
        check_value("rst_fev",   {31'd0, mx_fev},  32'd0);
        check_value("rst_fvec",  {24'd0, mx_fvec}, 32'd0);
        rst_n = 1'b1;

        // Correct NOR, N_IN=2
        run_sweep(0, 3'd0, busy_cyc, seq_err, done_seen);
        check_value("nor_done_seen", {31'd0, done_seen}, 32'd1);
        check_value("nor_busy_len",  busy_cyc, 32'd16);
        check_value("nor_stim_seq",  seq_err, 32'd0);
        check_value("nor_done_busy", {31'd0, mx_busy}, 32'd0);
        check_value("nor_done_stim", {24'd0, mx_stim}, 32'd0);
        check_value("nor_pass",      {31'd0, mx_pass}, 32'd1);
        check_value("nor_err",       {24'd0, mx_err},  32'd0);
        check_value("nor_fev",       {31'd0, mx_fev},  32'd0);
        @(negedge clk);
        check_value("nor_done_pulse", {31'd0, mx_done}, 32'd0);
        check_value("nor_pass_held",  {31'd0, mx_pass}, 32'd1);

        // NOR with output stuck at 0: only vector 00 mismatches
        stuck2 = 1'b1;
        run_sweep(0, 3'd0, busy_cyc, seq_err, done_seen);
        check_value("stk_done_seen", {31'd0, done_seen}, 32'd1);
        check_value("stk_err",       {24'd0, mx_err},  32'd1);
        check_value("stk_fev",       {31'd0, mx_fev},  32'd1);
        check_value("stk_fvec",      {24'd0, mx_fvec}, 32'd0);
        check_value("stk_pass",      {31'd0, mx_pass}, 32'd0);
        stuck2 = 1'b0;

        // XOR expected, gate is NAND3: mismatches on 0,3,5,6,7
        run_sweep(1, 3'd4, busy_cyc, seq_err, done_seen);
        check_value("xor_done_seen", {31'd0, done_seen}, 32'd1);
        check_value("xor_busy_len",  busy_cyc, 32'd32);
        check_value("xor_stim_seq",  seq_err, 32'd0);
        check_value("xor_err",       {24'd0, mx_err},  32'd5);
        check_value("xor_fev",       {31'd0, mx_fev},  32'd1);
        check_value("xor_fvec",      {24'd0, mx_fvec}, 32'd0);
        check_value("xor_pass",      {31'd0, mx_pass}, 32'd0);

        // XNOR expected, gate is XOR3: 8 mismatches saturate a 2-bit counter
        run_sweep(2, 3'd5, busy_cyc, seq_err, done_seen);
        check_value("sat_done_seen", {31'd0, done_seen}, 32'd1);
        check_value("sat_err",       {24'd0, mx_err},  32'd3);
        check_value("sat_fvec",      {24'd0, mx_fvec}, 32'd0);
        check_value("sat_pass",      {31'd0, mx_pass}, 32'd0);

        // Invalid mode aborts straight to DONE
        sel = 0;
        @(negedge clk);
        mode  = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("inv_done", {31'd0, mx_done}, 32'd1);
        check_value("inv_merr", {31'd0, mx_merr}, 32'd1);
        check_value("inv_pass", {31'd0, mx_pass}, 32'd0);
        busy_rose  = 1'b0;
        stim_moved = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (mx_busy) busy_rose = 1'b1;
            if (mx_stim != 8'd0) stim_moved = 1'b1;
            @(negedge clk);
        end
        check_value("inv_busy_never", {31'd0, busy_rose},  32'd0);
        check_value("inv_stim_zero",  {31'd0, stim_moved}, 32'd0);
        check_value("inv_done_gone",  {31'd0, mx_done},    32'd0);
        check_value("inv_merr_held",  {31'd0, mx_merr},    32'd1);

        // Mid-sweep start is ignored; mid-sweep reset aborts without done
        sel = 0;
        @(negedge clk);
        mode  = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin : wait_vec2
            for (int t = 0; t < 40; t++) begin
                if (mx_stim == 8'd2) disable wait_vec2;
                @(negedge clk);
            end
        end
        check_value("mid_reach_vec2", {24'd0, mx_stim}, 32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("mid_start_busy", {31'd0, mx_busy}, 32'd1);
        check_value("mid_start_stim", {24'd0, mx_stim}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_value("arst_stim", {24'd0, mx_stim}, 32'd0);
        check_value("arst_busy", {31'd0, mx_busy}, 32'd0);
        check_value("arst_merr", {31'd0, mx_merr}, 32'd0);
        check_value("arst_done", {31'd0, mx_done}, 32'd0);
        @(negedge clk);
        check_value("arst_no_done", {31'd0, mx_done}, 32'd0);
        rst_n = 1'b1;
        run_sweep(0, 3'd0, busy_cyc, seq_err, done_seen);
        check_value("rerun_done_seen", {31'd0, done_seen}, 32'd1);
        check_value("rerun_busy_len",  busy_cyc, 32'd16);
        check_value("rerun_pass",      {31'd0, mx_pass}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
